// File: rtl/ysyx_25060170_isram_pkg.sv
// Shared constants for the instruction SRAM responder: response codes,
// the reset PC used as the default base address, and FSM state encodings.
package ysyx_25060170_isram_pkg;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] RESET_PC    = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } isram_state_e;

endpackage

// File: rtl/ysyx_25060170_sram_array.sv
// DEPTH x 32 word store: one synchronous write port, one registered read port.
// A read and a write to the same word on one edge return the old word.
module ysyx_25060170_sram_array #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Both updates are non-blocking, so a same-edge read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ysyx_25060170_isram.sv
// Instruction-fetch read slave: one outstanding request, fixed response latency,
// address decode with SLVERR for misaligned or out-of-window requests.
module ysyx_25060170_isram
  import ysyx_25060170_isram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = RESET_PC,
  parameter int          DEPTH     = 4096,
  parameter int          LATENCY   = 1,
  localparam int         AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arvalid,
  output logic          arready,
  input  logic [31:0]   araddr,
  output logic          rvalid,
  input  logic          rready,
  output logic [31:0]   rdata,
  output logic [1:0]    rresp,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_idx,
  input  logic [31:0]   ld_data
);

  isram_state_e state_reg, state_next;
  logic [3:0]   cnt_reg, cnt_next;
  logic         ok_reg;
  logic [1:0]   rresp_reg;

  logic [31:0]  word_off;
  logic         addr_ok;
  logic         accept;
  logic [31:0]  sram_q;

  // Word offset from the window base; wraps huge when araddr is below the base.
  assign word_off = (araddr - BASE_ADDR) >> 2;
  assign addr_ok  = (araddr >= BASE_ADDR) && (araddr[1:0] == 2'b00) &&
                    (word_off < 32'(DEPTH));

  assign arready = (state_reg == IDLE) && !rst;
  assign accept  = arvalid && arready;

  assign rvalid = (state_reg == RESP) && !rst;
  assign rresp  = rst ? RESP_OKAY : rresp_reg;
  // The array output is only meaningful for an accepted in-window request.
  assign rdata  = (ok_reg && !rst) ? sram_q : 32'h0;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            cnt_next   = 4'(LATENCY - 1);
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      ok_reg    <= 1'b0;
      rresp_reg <= RESP_OKAY;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        ok_reg    <= addr_ok;
        rresp_reg <= addr_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  ysyx_25060170_sram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (ld_en),
    .waddr (ld_idx),
    .wdata (ld_data),
    .re    (accept && addr_ok),
    .raddr (word_off[AW-1:0]),
    .rdata (sram_q)
  );

endmodule

// File: tb/tb_ysyx_25060170_isram.sv
// Bench for the instruction SRAM responder: three instances at latencies 1, 3 and 4,
// each checked against a word-array reference model with the decode rules in plain arithmetic.
module tb_ysyx_25060170_isram;

  localparam int          NI    = 3;
  localparam int          DEPTH = 64;
  localparam int          AW    = 6;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst     [NI];
  logic          arvalid [NI];
  logic          arready [NI];
  logic [31:0]   araddr  [NI];
  logic          rvalid  [NI];
  logic          rready  [NI];
  logic [31:0]   rdata   [NI];
  logic [1:0]    rresp   [NI];
  logic          ld_en   [NI];
  logic [AW-1:0] ld_idx  [NI];
  logic [31:0]   ld_data [NI];

  logic [31:0] model [NI][DEPTH];
  int n_cmp = 0;
  int n_bad = 0;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      ysyx_25060170_isram #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .LATENCY   (gi == 0 ? 1 : (gi == 1 ? 3 : 4))
      ) u_dut (
        .clk     (clk),
        .rst     (rst[gi]),
        .arvalid (arvalid[gi]),
        .arready (arready[gi]),
        .araddr  (araddr[gi]),
        .rvalid  (rvalid[gi]),
        .rready  (rready[gi]),
        .rdata   (rdata[gi]),
        .rresp   (rresp[gi]),
        .ld_en   (ld_en[gi]),
        .ld_idx  (ld_idx[gi]),
        .ld_data (ld_data[gi])
      );
    end
  endgenerate

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  // Reference decode: in-window, word-aligned addresses read the model, all else is SLVERR/0.
  function automatic void ref_read(int k, logic [31:0] a, output logic [31:0] d,
                                   output logic [1:0] r, output int idx);
    longint ua, b;
    ua  = longint'(a);
    b   = longint'(BASE);
    idx = -1;
    if (ua < b || (ua % 4) != 0 || (ua - b) / 4 >= DEPTH) begin
      d = 32'h0;
      r = 2'b10;
    end else begin
      idx = int'((ua - b) / 4);
      d   = model[k][idx];
      r   = 2'b00;
    end
  endfunction

  task automatic load(int k, int idx, logic [31:0] d);
    @(negedge clk);
    ld_en[k]   = 1'b1;
    ld_idx[k]  = AW'(idx);
    ld_data[k] = d;
    @(posedge clk);
    model[k][idx] = d;
    #1 ld_en[k] = 1'b0;
  endtask

  // One read transaction: optional same-edge load at accept (collide), optional
  // overwrite of the in-flight word while stalled (clobber), hold = cycles of rready low.
  task automatic do_read(int k, logic [31:0] a, int hold, bit clobber,
                         bit collide, int cidx, logic [31:0] cdata);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    int idx, lat, waited;
    @(negedge clk);
    arvalid[k] = 1'b1;
    araddr[k]  = a;
    if (collide) begin
      ld_en[k]   = 1'b1;
      ld_idx[k]  = AW'(cidx);
      ld_data[k] = cdata;
    end
    waited = 0;
    while (arready[k] !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (arready[k] !== 1'b1) begin
      n_bad++;
      $display("FAIL accept_timeout k=%0d arready=%b required=1", k, arready[k]);
      arvalid[k] = 1'b0;
      ld_en[k]   = 1'b0;
      return;
    end
    ref_read(k, a, exp_d, exp_r, idx);
    @(posedge clk);
    if (collide) model[k][cidx] = cdata;
    @(negedge clk);
    arvalid[k] = 1'b0;
    ld_en[k]   = 1'b0;
    araddr[k]  = $urandom();
    n_cmp++;
    if (arready[k] !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_arready k=%0d arready=%b required=0", k, arready[k]);
    end
    lat = 1;
    while (rvalid[k] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat !== lat_of(k)) begin
      n_bad++;
      $display("FAIL latency k=%0d edges=%0d required=%0d", k, lat, lat_of(k));
    end
    n_cmp++;
    if (rdata[k] !== exp_d || rresp[k] !== exp_r) begin
      n_bad++;
      $display("FAIL response k=%0d addr=%h data=%h resp=%b required data=%h resp=%b",
               k, a, rdata[k], rresp[k], exp_d, exp_r);
    end
    for (int i = 0; i < hold; i++) begin
      rready[k] = 1'b0;
      if (i == 0 && clobber && idx >= 0) begin
        ld_en[k]   = 1'b1;
        ld_idx[k]  = AW'(idx);
        ld_data[k] = ~exp_d;
      end
      @(posedge clk);
      if (ld_en[k]) model[k][idx] = ~exp_d;
      @(negedge clk);
      ld_en[k] = 1'b0;
      n_cmp++;
      if (rvalid[k] !== 1'b1 || rdata[k] !== exp_d || rresp[k] !== exp_r) begin
        n_bad++;
        $display("FAIL stall_stable k=%0d cyc=%0d rvalid=%b data=%h resp=%b required 1/%h/%b",
                 k, i, rvalid[k], rdata[k], rresp[k], exp_d, exp_r);
      end
    end
    rready[k] = 1'b1;
    @(negedge clk);
    rready[k] = 1'b0;
    n_cmp++;
    if (rvalid[k] !== 1'b0 || arready[k] !== 1'b1) begin
      n_bad++;
      $display("FAIL release k=%0d rvalid=%b arready=%b required 0/1", k, rvalid[k], arready[k]);
    end
    $display("txn k=%0d addr=%h data=%h resp=%b lat=%0d hold=%0d", k, a, exp_d, exp_r, lat, hold);
  endtask

  task automatic test_reset();
    for (int k = 0; k < NI; k++) rst[k] = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if (rvalid[k] !== 1'b0 || rdata[k] !== 32'h0 || rresp[k] !== 2'b00 || arready[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_state k=%0d rvalid=%b data=%h resp=%b arready=%b required 0/0/00/0",
                 k, rvalid[k], rdata[k], rresp[k], arready[k]);
      end
      rst[k] = 1'b0;
    end
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if (arready[k] !== 1'b1 || rvalid[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL post_reset k=%0d arready=%b rvalid=%b required 1/0", k, arready[k], rvalid[k]);
      end
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if (rvalid[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_no_resp k=%0d rvalid=%b required=0", k, rvalid[k]);
      end
    end
  endtask

  task automatic test_basic();
    load(0, 0, 32'h0000_0413);
    load(0, 1, 32'h0010_0073);
    do_read(0, BASE, 0, 1'b0, 1'b0, 0, 32'h0);
    do_read(0, BASE + 32'h4, 0, 1'b0, 1'b0, 0, 32'h0);
  endtask

  task automatic test_backpressure();
    load(1, 2, 32'hDEAD_BEEF);
    do_read(1, BASE + 32'h8, 5, 1'b1, 1'b0, 0, 32'h0);
    do_read(1, BASE + 32'h8, 0, 1'b0, 1'b0, 0, 32'h0);
  endtask

  task automatic test_errors();
    for (int k = 0; k < 2; k++) begin
      load(k, 0, 32'h1234_5678);
      do_read(k, 32'h8000_0002, 1, 1'b0, 1'b0, 0, 32'h0);
      do_read(k, 32'h7FFF_FFFC, 0, 1'b0, 1'b0, 0, 32'h0);
      do_read(k, BASE + 32'(4 * DEPTH), 0, 1'b0, 1'b0, 0, 32'h0);
      do_read(k, BASE, 0, 1'b0, 1'b0, 0, 32'h0);
    end
  endtask

  task automatic test_collision();
    load(0, 5, 32'h1111_1111);
    do_read(0, BASE + 32'h14, 0, 1'b0, 1'b1, 5, 32'h2222_2222);
    do_read(0, BASE + 32'h14, 0, 1'b0, 1'b0, 0, 32'h0);
  endtask

  task automatic test_reset_mid();
    int waited;
    load(2, 3, 32'hCAFE_F00D);
    @(negedge clk);
    arvalid[2] = 1'b1;
    araddr[2]  = BASE + 32'hC;
    waited = 0;
    while (arready[2] !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    arvalid[2] = 1'b0;
    @(negedge clk);
    rst[2]    = 1'b1;
    rready[2] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rvalid[2] !== 1'b0 || arready[2] !== 1'b0 || rdata[2] !== 32'h0 || rresp[2] !== 2'b00) begin
        n_bad++;
        $display("FAIL mid_reset cyc=%0d rvalid=%b arready=%b data=%h resp=%b required 0/0/0/00",
                 i, rvalid[2], arready[2], rdata[2], rresp[2]);
      end
    end
    rst[2]    = 1'b0;
    rready[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rvalid[2] !== 1'b0 || arready[2] !== 1'b1) begin
        n_bad++;
        $display("FAIL aborted_txn cyc=%0d rvalid=%b arready=%b required 0/1", i, rvalid[2], arready[2]);
      end
    end
    do_read(2, BASE + 32'hC, 2, 1'b0, 1'b0, 0, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < DEPTH; i++) load(k, i, $urandom());
      for (int t = 0; t < 25; t++) begin
        case ($urandom_range(0, 9))
          0:       a = BASE + 32'($urandom_range(1, 3)) + 32'(4 * $urandom_range(0, DEPTH - 1));
          1:       a = BASE - 32'(4 * $urandom_range(1, 8));
          2:       a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 8));
          3:       a = $urandom();
          default: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        endcase
        do_read(k, a, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), $urandom());
      end
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k]     = 1'b1;
      arvalid[k] = 1'b0;
      araddr[k]  = 32'h0;
      rready[k]  = 1'b0;
      ld_en[k]   = 1'b0;
      ld_idx[k]  = '0;
      ld_data[k] = 32'h0;
    end
    test_reset();
    test_basic();
    test_backpressure();
    test_errors();
    test_collision();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
